// File: rtl/pc_fetch_unit_pkg.sv
// Shared types, state encodings and reset defaults for the instruction-fetch slice.
package pc_fetch_unit_pkg;

    typedef logic [29:0] word_addr_t;
    typedef logic [31:0] instr_t;

    localparam word_addr_t RESET_PC_WORD = 30'h0000_0C00;

    localparam logic [0:0] FETCH_IDLE = 1'b0;
    localparam logic [0:0] FETCH_REQ  = 1'b1;

    // Watchdog counter width: it must be able to hold TIMEOUT itself so it can saturate.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Clear/enable watchdog counter; tc flags the last cycle the fetch is allowed to wait.
module fetch_timer
    import pc_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int TW = timer_width(TIMEOUT);

    logic [TW-1:0] count;

    // Saturate at TIMEOUT so a stuck enable can never wrap back into range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus the req/ack instruction-fetch FSM of the multi-cycle CPU.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [29:0] RESET_PC = RESET_PC_WORD,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic [29:0] npc,
    input  logic        fetch_start,
    output logic [29:0] pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    logic [0:0] state;
    logic       timer_tc;
    logic       in_req;

    assign in_req   = (state == FETCH_REQ);
    assign imem_req = in_req;
    assign busy     = in_req;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_req),
        .enable (in_req && !imem_ack),
        .tc     (timer_tc)
    );

    // pc is independent of the FSM; the fetch address is a private snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_wr) begin
            pc <= npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_IDLE;
            imem_addr  <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (fetch_start) begin
                        state     <= FETCH_REQ;
                        imem_addr <= pc;
                        ir_valid  <= 1'b0;
                        fetch_err <= 1'b0;
                    end
                end
                FETCH_REQ: begin
                    // An ack in the final allowed cycle still completes the fetch.
                    if (imem_ack) begin
                        ir         <= imem_rdata;
                        ir_valid   <= 1'b1;
                        fetch_done <= 1'b1;
                        state      <= FETCH_IDLE;
                    end else if (timer_tc) begin
                        fetch_err <= 1'b1;
                        state     <= FETCH_IDLE;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;

    localparam int          TO    = 16;
    localparam logic [29:0] RPC   = 30'h0000_0C00;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr;
    logic [29:0] npc;
    logic        fetch_start;
    logic [29:0] pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    logic [29:0] exp_pc;
    logic [31:0] exp_ir;
    logic        exp_valid;
    logic        exp_err;
    logic [29:0] exp_addr;
    logic [31:0] got_word;
    int          n;
    int          d;
    int          idle_n;
    int          exp_len;

    pc_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_wr       (pc_wr),
        .npc         (npc),
        .fetch_start (fetch_start),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model's pc follows pc_wr as sampled at the edge.
    task automatic step();
        @(posedge clk);
        if (pc_wr) exp_pc = npc;
        #1;
    endtask

    // Run REQ cycles until imem_req drops, acking on REQ cycle ack_at (0 = never).
    task automatic run_req(input int ack_at, input bit noisy);
        n = 0;
        while (imem_req === 1'b1 && n < TO + 4) begin
            n++;
            chk("req_addr", {2'b0, imem_addr}, {2'b0, exp_addr});
            chk("req_busy", {31'b0, busy}, 32'd1);
            imem_ack   = (n == ack_at);
            imem_rdata = $urandom;
            if (imem_ack) got_word = imem_rdata;
            if (noisy) begin
                fetch_start = 1'($urandom_range(0, 1));
                pc_wr       = 1'($urandom_range(0, 1));
                npc         = 30'($urandom);
            end
            step();
        end
        imem_ack    = 1'b0;
        fetch_start = 1'b0;
        pc_wr       = 1'b0;
    endtask

    task automatic start_fetch();
        exp_addr    = exp_pc;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pc"},    {2'b0, pc}, {2'b0, exp_pc});
        chk({tag, "_ir"},    ir, exp_ir);
        chk({tag, "_valid"}, {31'b0, ir_valid}, {31'b0, exp_valid});
        chk({tag, "_err"},   {31'b0, fetch_err}, {31'b0, exp_err});
    endtask

    initial begin
        rst = 1'b1; pc_wr = 1'b0; npc = '0; fetch_start = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        exp_pc = RPC; exp_ir = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_addr = '0;
        got_word = '0;
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", {2'b0, imem_addr}, 32'd0);
        chk("rst_done", {31'b0, fetch_done}, 32'd0);
        chk_state("rst");
        rst = 1'b0;
        step();

        // Immediate ack with a known instruction word.
        start_fetch();
        chk("f1_req", {31'b0, imem_req}, 32'd1);
        chk("f1_addr", {2'b0, imem_addr}, {2'b0, RPC});
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        step();
        imem_ack = 1'b0;
        exp_ir = 32'h2408_0005; exp_valid = 1'b1;
        chk("f1_done", {31'b0, fetch_done}, 32'd1);
        chk("f1_req_off", {31'b0, imem_req}, 32'd0);
        chk_state("f1");
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("f1_done_off", {31'b0, fetch_done}, 32'd0);
        chk("stray_ack_ir", ir, exp_ir);

        // Ack on the 6th REQ cycle.
        start_fetch();
        run_req(6, 1'b0);
        chk("d5_len", n, 32'd6);
        exp_ir = got_word; exp_valid = 1'b1;
        chk("d5_done", {31'b0, fetch_done}, 32'd1);
        chk_state("d5");

        // Never acknowledged: watchdog aborts after TO REQ cycles.
        start_fetch();
        run_req(0, 1'b0);
        chk("to_len", n, TO);
        exp_err = 1'b1;
        chk("to_done", {31'b0, fetch_done}, 32'd0);
        chk_state("to");
        step();
        chk("to_sticky", {31'b0, fetch_err}, 32'd1);

        // pc_wr during REQ moves pc but not the fetch address.
        start_fetch();
        chk("err_clr", {31'b0, fetch_err}, 32'd0);
        pc_wr = 1'b1; npc = 30'h0C05;
        step();
        pc_wr = 1'b0;
        chk("pcwr_pc", {2'b0, pc}, 32'h0C05);
        chk("pcwr_addr", {2'b0, imem_addr}, {2'b0, RPC});
        run_req(1, 1'b0);
        exp_ir = got_word; exp_valid = 1'b1;
        chk_state("pcwr");

        // Simultaneous pc_wr and fetch_start: fetch uses the old pc.
        exp_addr = exp_pc;
        fetch_start = 1'b1; pc_wr = 1'b1; npc = 30'h0C10;
        step();
        fetch_start = 1'b0; pc_wr = 1'b0;
        exp_valid = 1'b0;
        chk("sim_addr", {2'b0, imem_addr}, 32'h0C05);
        chk("sim_pc", {2'b0, pc}, 32'h0C10);
        run_req(3, 1'b0);
        exp_ir = got_word; exp_valid = 1'b1;
        chk_state("sim");

        // Async reset in the middle of a request.
        start_fetch();
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        exp_pc = RPC; exp_ir = '0; exp_valid = 1'b0; exp_err = 1'b0;
        chk_state("arst");
        rst = 1'b0;
        pc_wr = 1'b1; npc = 30'h3FFF_FFFF;
        step();
        chk("wrap_max", {2'b0, pc}, 32'h3FFF_FFFF);
        npc = pc + 30'd1;
        step();
        pc_wr = 1'b0;
        chk("wrap_zero", {2'b0, pc}, 32'd0);

        // Randomized fetches: ack delay drawn across and beyond the timeout window.
        for (int t = 0; t < 40; t++) begin
            idle_n = $urandom_range(0, 3);
            for (int i = 0; i < idle_n; i++) begin
                pc_wr = 1'($urandom_range(0, 1)); npc = 30'($urandom);
                imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
                step();
                chk("idle_req", {31'b0, imem_req}, 32'd0);
                chk("idle_ir", ir, exp_ir);
            end
            pc_wr = 1'($urandom_range(0, 1)); npc = 30'($urandom); imem_ack = 1'b0;
            d = $urandom_range(0, TO + 2);
            start_fetch();
            pc_wr = 1'b0;
            chk("rnd_start_err", {31'b0, fetch_err}, 32'd0);
            run_req((d < TO) ? d + 1 : 0, 1'b1);
            if (d < TO) begin
                exp_len = d + 1; exp_ir = got_word; exp_valid = 1'b1;
            end else begin
                exp_len = TO; exp_err = 1'b1;
            end
            chk("rnd_len", n, exp_len);
            chk("rnd_done", {31'b0, fetch_done}, {31'b0, (d < TO)});
            chk_state("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
